// File: rtl/multicycle_control_unit_if.sv
// Control/handshake bundle between the multicycle control FSM and the datapath.
// Ports: ins/mem_ready flow from datapath into the FSM; out_signals, ALUOp, state,
//        instr_done and illegal_op flow from the FSM out to the datapath.
interface multicycle_control_unit_if #(
    parameter int NUM_SIGNALS = 15,
    parameter int ALUOP_WIDTH = 3
);
    logic [5:0]             ins;
    logic                   mem_ready;
    logic [NUM_SIGNALS-1:0] out_signals;
    logic [ALUOP_WIDTH-1:0] ALUOp;
    logic [3:0]             state;
    logic                   instr_done;
    logic                   illegal_op;

    // Control unit side
    modport master (
        input  ins, mem_ready,
        output out_signals, ALUOp, state, instr_done, illegal_op
    );

    // Datapath side
    modport slave (
        output ins, mem_ready,
        input  out_signals, ALUOp, state, instr_done, illegal_op
    );
endinterface

// File: rtl/multicycle_control_unit.sv
// Multicycle MIPS main control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK sequencing.
// Latency: LW 5, SW/R/I 4, BEQ/BNE/J 3, illegal 2 cycles with memory always ready.
// Backpressure: FETCH, MEM_RD and MEM_WR hold until mem_ready; strobes stay asserted while stalled.
//
// Ports: clk, rst_n (async active-low), bus (multicycle_control_unit_if.master).
// Optional macro PERF_CNT_EN adds output retired_cnt counting completed legal instructions.
// NUM_SIGNALS must be >= 15 and ALUOP_WIDTH >= 3; extra upper bits are driven 0.
module multicycle_control_unit #(
    parameter int NUM_SIGNALS    = 15,
    parameter int ALUOP_WIDTH    = 3,
    parameter int PERF_CNT_WIDTH = 32
) (
    input  logic                      clk,
    input  logic                      rst_n,
    multicycle_control_unit_if.master bus
`ifdef PERF_CNT_EN
    ,
    output logic [PERF_CNT_WIDTH-1:0] retired_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_R_EXEC   = 4'd6,
        S_R_WB     = 4'd7,
        S_BR_EX    = 4'd8,
        S_J_EX     = 4'd9,
        S_I_EXEC   = 4'd10,
        S_I_WB     = 4'd11
    } state_e;

    localparam logic [5:0] OP_R     = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    localparam logic [2:0] ALU_ADD   = 3'b000;
    localparam logic [2:0] ALU_SUB   = 3'b001;
    localparam logic [2:0] ALU_FUNCT = 3'b010;
    localparam logic [2:0] ALU_AND   = 3'b011;
    localparam logic [2:0] ALU_OR    = 3'b100;
    localparam logic [2:0] ALU_SLT   = 3'b101;

    // Bit positions inside the control word
    localparam int B_REGDST   = 0;
    localparam int B_BRANCH   = 1;
    localparam int B_MEMREAD  = 2;
    localparam int B_MEMTOREG = 3;
    localparam int B_MEMWRITE = 4;
    localparam int B_ALUSRCA  = 5;
    localparam int B_REGWRITE = 6;
    localparam int B_PCWRITE  = 7;
    localparam int B_IORD     = 8;
    localparam int B_IRWRITE  = 9;
    localparam int B_SRCB_LO  = 10;
    localparam int B_PCSRC_LO = 12;
    localparam int B_BRANCHNE = 14;

    state_e      state_q, state_d;
    logic [5:0]  op_q, op_d;
    logic [14:0] ctl;
    logic [2:0]  alu_op;
    logic        done;
    logic        illegal;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            op_q    <= 6'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ctl     = '0;
        alu_op  = ALU_ADD;
        done    = 1'b0;
        illegal = 1'b0;
        case (state_q)
            S_FETCH: begin
                ctl[B_MEMREAD]              = 1'b1;
                ctl[B_SRCB_LO+1:B_SRCB_LO]  = 2'b01;
                ctl[B_IRWRITE]              = bus.mem_ready;
                ctl[B_PCWRITE]              = bus.mem_ready;
                if (bus.mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ctl[B_SRCB_LO+1:B_SRCB_LO] = 2'b11;
                op_d = bus.ins;
                // Next state is steered by the live opcode; op_q is loaded on the same edge.
                case (bus.ins)
                    OP_LW, OP_SW:   state_d = S_MEM_ADDR;
                    OP_R:           state_d = S_R_EXEC;
                    OP_BEQ, OP_BNE: state_d = S_BR_EX;
                    OP_J:           state_d = S_J_EX;
                    OP_ADDI, OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI:
                                    state_d = S_I_EXEC;
                    default: begin
                        illegal = 1'b1;
                        state_d = S_FETCH;
                    end
                endcase
            end
            S_MEM_ADDR: begin
                ctl[B_ALUSRCA]             = 1'b1;
                ctl[B_SRCB_LO+1:B_SRCB_LO] = 2'b10;
                state_d = (op_q == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                ctl[B_MEMREAD] = 1'b1;
                ctl[B_IORD]    = 1'b1;
                if (bus.mem_ready) state_d = S_MEM_WB;
            end
            S_MEM_WB: begin
                ctl[B_MEMTOREG] = 1'b1;
                ctl[B_REGWRITE] = 1'b1;
                done    = 1'b1;
                state_d = S_FETCH;
            end
            S_MEM_WR: begin
                // The write strobe is held for the whole stall so slow memory sees a stable request.
                ctl[B_MEMWRITE] = 1'b1;
                ctl[B_IORD]     = 1'b1;
                if (bus.mem_ready) begin
                    done    = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_R_EXEC: begin
                ctl[B_ALUSRCA] = 1'b1;
                alu_op  = ALU_FUNCT;
                state_d = S_R_WB;
            end
            S_R_WB: begin
                ctl[B_REGDST]   = 1'b1;
                ctl[B_REGWRITE] = 1'b1;
                done    = 1'b1;
                state_d = S_FETCH;
            end
            S_BR_EX: begin
                ctl[B_ALUSRCA]                 = 1'b1;
                ctl[B_PCSRC_LO+1:B_PCSRC_LO]   = 2'b01;
                ctl[B_BRANCH]                  = (op_q == OP_BEQ);
                ctl[B_BRANCHNE]                = (op_q == OP_BNE);
                alu_op  = ALU_SUB;
                done    = 1'b1;
                state_d = S_FETCH;
            end
            S_J_EX: begin
                ctl[B_PCWRITE]               = 1'b1;
                ctl[B_PCSRC_LO+1:B_PCSRC_LO] = 2'b10;
                done    = 1'b1;
                state_d = S_FETCH;
            end
            S_I_EXEC: begin
                ctl[B_ALUSRCA]             = 1'b1;
                ctl[B_SRCB_LO+1:B_SRCB_LO] = 2'b10;
                case (op_q)
                    OP_ANDI: alu_op = ALU_AND;
                    OP_ORI:  alu_op = ALU_OR;
                    OP_SLTI: alu_op = ALU_SLT;
                    default: alu_op = ALU_ADD;
                endcase
                state_d = S_I_WB;
            end
            S_I_WB: begin
                ctl[B_REGWRITE] = 1'b1;
                done    = 1'b1;
                state_d = S_FETCH;
            end
            default: begin
                // Unused encodings: all outputs quiet, recover to FETCH.
                state_d = S_FETCH;
            end
        endcase
    end

    // Outputs are gated by rst_n so the reset state (FETCH) never asserts a strobe
    // while reset is held, including asynchronously mid-cycle.
    always_comb begin
        bus.out_signals = '0;
        bus.ALUOp       = '0;
        if (rst_n) begin
            bus.out_signals[14:0] = ctl;
            bus.ALUOp[2:0]        = alu_op;
        end
    end

    assign bus.state      = state_q;
    assign bus.instr_done = rst_n & done;
    assign bus.illegal_op = rst_n & illegal;

`ifdef PERF_CNT_EN
    logic [PERF_CNT_WIDTH-1:0] retired_cnt_q, retired_cnt_d;

    // Natural modulo-2^N wrap on overflow.
    always_comb begin
        retired_cnt_d = retired_cnt_q;
        if (bus.instr_done) retired_cnt_d = retired_cnt_q + PERF_CNT_WIDTH'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) retired_cnt_q <= '0;
        else        retired_cnt_q <= retired_cnt_d;
    end

    assign retired_cnt = retired_cnt_q;
`endif

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Directed bench for multicycle_control_unit: per-cycle expectations queued as stimulus is driven.
// Latency: each step is one clock; outputs sampled 1ns after the falling edge.
// Backpressure: mem_ready is driven per step to create fetch/read/write stalls.
module tb_multicycle_control_unit;

    localparam logic [14:0] B_REGDST   = 15'h0001;
    localparam logic [14:0] B_BRANCH   = 15'h0002;
    localparam logic [14:0] B_MEMREAD  = 15'h0004;
    localparam logic [14:0] B_MEMTOREG = 15'h0008;
    localparam logic [14:0] B_MEMWRITE = 15'h0010;
    localparam logic [14:0] B_SRCA     = 15'h0020;
    localparam logic [14:0] B_REGWRITE = 15'h0040;
    localparam logic [14:0] B_PCWRITE  = 15'h0080;
    localparam logic [14:0] B_IORD     = 15'h0100;
    localparam logic [14:0] B_IRWRITE  = 15'h0200;
    localparam logic [14:0] SRCB_01    = 15'h0400;
    localparam logic [14:0] SRCB_10    = 15'h0800;
    localparam logic [14:0] SRCB_11    = 15'h0C00;
    localparam logic [14:0] PCS_01     = 15'h1000;
    localparam logic [14:0] PCS_10     = 15'h2000;
    localparam logic [14:0] B_BNE      = 15'h4000;

    localparam logic [14:0] FETCH_N = B_MEMREAD | SRCB_01;
    localparam logic [14:0] FETCH_Y = B_MEMREAD | SRCB_01 | B_IRWRITE | B_PCWRITE;

    localparam logic [5:0] OP_R   = 6'b000000;
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_SW  = 6'b101011;
    localparam logic [5:0] OP_BEQ = 6'b000100;
    localparam logic [5:0] OP_BNE = 6'b000101;
    localparam logic [5:0] OP_J   = 6'b000010;
    localparam logic [5:0] OP_ORI = 6'b001101;
    localparam logic [5:0] OP_SLTI= 6'b001010;
    localparam logic [5:0] OP_BAD = 6'b111111;

    typedef struct {
        string       tag;
        logic [3:0]  st;
        logic [14:0] sig;
        logic [2:0]  alu;
        logic        done;
        logic        ill;
    } exp_t;

    logic clk;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic [31:0] exp_cnt = 0;

    multicycle_control_unit_if #(.NUM_SIGNALS(15), .ALUOP_WIDTH(3)) bus ();

`ifdef PERF_CNT_EN
    logic [31:0] retired_cnt;
`endif

    multicycle_control_unit #(
        .NUM_SIGNALS(15),
        .ALUOP_WIDTH(3),
        .PERF_CNT_WIDTH(32)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
`ifdef PERF_CNT_EN
        ,
        .retired_cnt(retired_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Pop the oldest expectation and compare it against the current DUT outputs.
    task automatic compare();
        exp_t e;
        if (sb.size() == 0) begin
            chk("sb_empty", 32'd1, 32'd0);
            return;
        end
        e = sb.pop_front();
        chk({e.tag, ".state"}, {28'b0, bus.state},       {28'b0, e.st});
        chk({e.tag, ".sig"},   {17'b0, bus.out_signals}, {17'b0, e.sig});
        chk({e.tag, ".aluop"}, {29'b0, bus.ALUOp},       {29'b0, e.alu});
        chk({e.tag, ".done"},  {31'b0, bus.instr_done},  {31'b0, e.done});
        chk({e.tag, ".ill"},   {31'b0, bus.illegal_op},  {31'b0, e.ill});
`ifdef PERF_CNT_EN
        chk({e.tag, ".cnt"}, retired_cnt, exp_cnt);
`endif
        if (e.done && rst_n) exp_cnt = exp_cnt + 1;
    endtask

    // One clock: drive inputs, queue the expectation, sample after settle, advance to next falling edge.
    task automatic step(input string tag, input logic [5:0] i, input logic r,
                        input logic [3:0] es, input logic [14:0] esig,
                        input logic [2:0] ea, input logic ed, input logic ei);
        exp_t e;
        bus.ins       = i;
        bus.mem_ready = r;
        e.tag = tag; e.st = es; e.sig = esig; e.alu = ea; e.done = ed; e.ill = ei;
        sb.push_back(e);
        #1;
        compare();
        @(negedge clk);
    endtask

    initial begin
        exp_t e;
        rst_n         = 1'b0;
        bus.ins       = 6'b0;
        bus.mem_ready = 1'b0;
        @(negedge clk);
        step("rst0", OP_R, 1'b1, 4'd0, 15'h0, 3'd0, 1'b0, 1'b0);
        step("rst1", OP_R, 1'b1, 4'd0, 15'h0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // LW with fetch and read stalls
        step("lw_f0",   OP_LW, 1'b0, 4'd0, FETCH_N, 3'd0, 1'b0, 1'b0);
        step("lw_f1",   OP_LW, 1'b0, 4'd0, FETCH_N, 3'd0, 1'b0, 1'b0);
        step("lw_f2",   OP_LW, 1'b1, 4'd0, FETCH_Y, 3'd0, 1'b0, 1'b0);
        step("lw_dec",  OP_LW, 1'b1, 4'd1, SRCB_11, 3'd0, 1'b0, 1'b0);
        step("lw_addr", OP_R,  1'b1, 4'd2, B_SRCA | SRCB_10, 3'd0, 1'b0, 1'b0);
        step("lw_rd0",  OP_R,  1'b0, 4'd3, B_MEMREAD | B_IORD, 3'd0, 1'b0, 1'b0);
        step("lw_rd1",  OP_R,  1'b1, 4'd3, B_MEMREAD | B_IORD, 3'd0, 1'b0, 1'b0);
        step("lw_wb",   OP_R,  1'b1, 4'd4, B_MEMTOREG | B_REGWRITE, 3'd0, 1'b1, 1'b0);

        // R-type
        step("r_f",   OP_R, 1'b1, 4'd0, FETCH_Y, 3'd0, 1'b0, 1'b0);
        step("r_dec", OP_R, 1'b1, 4'd1, SRCB_11, 3'd0, 1'b0, 1'b0);
        step("r_ex",  OP_R, 1'b1, 4'd6, B_SRCA, 3'd2, 1'b0, 1'b0);
        step("r_wb",  OP_R, 1'b1, 4'd7, B_REGDST | B_REGWRITE, 3'd0, 1'b1, 1'b0);

        // BNE then BEQ
        step("bne_f",   OP_BNE, 1'b1, 4'd0, FETCH_Y, 3'd0, 1'b0, 1'b0);
        step("bne_dec", OP_BNE, 1'b1, 4'd1, SRCB_11, 3'd0, 1'b0, 1'b0);
        step("bne_ex",  OP_BEQ, 1'b1, 4'd8, B_SRCA | PCS_01 | B_BNE, 3'd1, 1'b1, 1'b0);
        step("beq_f",   OP_BEQ, 1'b1, 4'd0, FETCH_Y, 3'd0, 1'b0, 1'b0);
        step("beq_dec", OP_BEQ, 1'b1, 4'd1, SRCB_11, 3'd0, 1'b0, 1'b0);
        step("beq_ex",  OP_BNE, 1'b1, 4'd8, B_SRCA | PCS_01 | B_BRANCH, 3'd1, 1'b1, 1'b0);

        // J
        step("j_f",   OP_J, 1'b1, 4'd0, FETCH_Y, 3'd0, 1'b0, 1'b0);
        step("j_dec", OP_J, 1'b1, 4'd1, SRCB_11, 3'd0, 1'b0, 1'b0);
        step("j_ex",  OP_J, 1'b1, 4'd9, B_PCWRITE | PCS_10, 3'd0, 1'b1, 1'b0);

        // ORI and SLTI
        step("ori_f",   OP_ORI,  1'b1, 4'd0,  FETCH_Y, 3'd0, 1'b0, 1'b0);
        step("ori_dec", OP_ORI,  1'b1, 4'd1,  SRCB_11, 3'd0, 1'b0, 1'b0);
        step("ori_ex",  OP_R,    1'b1, 4'd10, B_SRCA | SRCB_10, 3'd4, 1'b0, 1'b0);
        step("ori_wb",  OP_R,    1'b1, 4'd11, B_REGWRITE, 3'd0, 1'b1, 1'b0);
        step("slti_f",  OP_SLTI, 1'b1, 4'd0,  FETCH_Y, 3'd0, 1'b0, 1'b0);
        step("slti_dec",OP_SLTI, 1'b1, 4'd1,  SRCB_11, 3'd0, 1'b0, 1'b0);
        step("slti_ex", OP_SLTI, 1'b1, 4'd10, B_SRCA | SRCB_10, 3'd5, 1'b0, 1'b0);
        step("slti_wb", OP_SLTI, 1'b1, 4'd11, B_REGWRITE, 3'd0, 1'b1, 1'b0);

        // Illegal opcode: no strobes, no retire
        step("bad_f",   OP_BAD, 1'b1, 4'd0, FETCH_Y, 3'd0, 1'b0, 1'b0);
        step("bad_dec", OP_BAD, 1'b1, 4'd1, SRCB_11, 3'd0, 1'b0, 1'b1);
        step("bad_nxt", OP_BAD, 1'b0, 4'd0, FETCH_N, 3'd0, 1'b0, 1'b0);

        // SW completing after a write stall
        step("sw_f",    OP_SW, 1'b1, 4'd0, FETCH_Y, 3'd0, 1'b0, 1'b0);
        step("sw_dec",  OP_SW, 1'b1, 4'd1, SRCB_11, 3'd0, 1'b0, 1'b0);
        step("sw_addr", OP_R,  1'b1, 4'd2, B_SRCA | SRCB_10, 3'd0, 1'b0, 1'b0);
        step("sw_wr0",  OP_R,  1'b0, 4'd5, B_MEMWRITE | B_IORD, 3'd0, 1'b0, 1'b0);
        step("sw_wr1",  OP_R,  1'b1, 4'd5, B_MEMWRITE | B_IORD, 3'd0, 1'b1, 1'b0);

        // SW stalled in MEM_WR, then reset mid-cycle
        step("sw2_f",    OP_SW, 1'b1, 4'd0, FETCH_Y, 3'd0, 1'b0, 1'b0);
        step("sw2_dec",  OP_SW, 1'b1, 4'd1, SRCB_11, 3'd0, 1'b0, 1'b0);
        step("sw2_addr", OP_R,  1'b0, 4'd2, B_SRCA | SRCB_10, 3'd0, 1'b0, 1'b0);
        step("sw2_wr0",  OP_R,  1'b0, 4'd5, B_MEMWRITE | B_IORD, 3'd0, 1'b0, 1'b0);
        #2;
        rst_n   = 1'b0;
        exp_cnt = 0;
        e.tag = "arst_now"; e.st = 4'd0; e.sig = 15'h0; e.alu = 3'd0; e.done = 1'b0; e.ill = 1'b0;
        sb.push_back(e);
        #1;
        compare();
        @(negedge clk);
        step("arst_a", OP_SW, 1'b1, 4'd0, 15'h0, 3'd0, 1'b0, 1'b0);
        step("arst_b", OP_SW, 1'b1, 4'd0, 15'h0, 3'd0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Fetch resumes with a fresh R-type
        step("post_f",   OP_R, 1'b1, 4'd0, FETCH_Y, 3'd0, 1'b0, 1'b0);
        step("post_dec", OP_R, 1'b1, 4'd1, SRCB_11, 3'd0, 1'b0, 1'b0);
        step("post_ex",  OP_R, 1'b1, 4'd6, B_SRCA, 3'd2, 1'b0, 1'b0);
        step("post_wb",  OP_R, 1'b1, 4'd7, B_REGDST | B_REGWRITE, 3'd0, 1'b1, 1'b0);
        step("post_f2",  OP_R, 1'b0, 4'd0, FETCH_N, 3'd0, 1'b0, 1'b0);

        chk("sb_drained", sb.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
